// File: rtl/kolache_alu_pkg.sv
// Shared definitions for the Kolache ALU execute-stage blocks.
// Holds the default datapath width, the divider state encoding width and
// the divider state enum used by kolache_divider.
package kolache_alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DIV_STATE_W   = 2;

    typedef enum logic [DIV_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/kolache_div_step.sv
// One combinational restoring-division step.
// Shifts the incoming dividend bit into the partial remainder and
// trial-subtracts the divisor using an adder in subtract mode.
// Ports:
//   rem      in   WIDTH  current partial remainder (always < divisor)
//   in_bit   in   1      next dividend bit, MSB first
//   divisor  in   WIDTH  divisor
//   rem_next out  WIDTH  partial remainder after this step
//   q_bit    out  1      quotient bit (1 = trial subtraction did not borrow)
module kolache_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    localparam logic SUB = 1'b1;

    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;

    // The shifted remainder is WIDTH+1 bits: {rem[WIDTH-1], low}. Only the
    // low WIDTH bits go through the adder; a set top bit means the shifted
    // value is >= 2^WIDTH and therefore can never borrow, and the true
    // difference still fits in WIDTH bits, so the low adder result is exact.
    always_comb begin
        low      = {rem[WIDTH-2:0], in_bit};
        b_op     = divisor ^ {WIDTH{SUB}};
        sum      = {1'b0, low} + {1'b0, b_op} + {{WIDTH{1'b0}}, SUB};
        q_bit    = rem[WIDTH-1] | sum[WIDTH];
        rem_next = q_bit ? sum[WIDTH-1:0] : low;
    end

endmodule

// File: rtl/kolache_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Optional macro KOLACHE_DIV_ZERO_FAST_EN: a zero divisor skips RUN and
// reports the divide-by-zero result one cycle after acceptance.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request, accepted only while ready=1
//   dividend     unsigned dividend, sampled on acceptance
//   divisor      unsigned divisor, sampled on acceptance
//   ready        high in IDLE
//   done         one-cycle pulse, results valid from this cycle
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered, set when the accepted divisor was 0
module kolache_divider
    import kolache_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    kolache_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r),
        .in_bit   (q_work[WIDTH-1]),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Results are loaded on the edge entering DONE (from the final step's
    // outputs) so they are valid in the same cycle as the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q_work      <= '0;
            dvsr        <= '0;
            count       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvsr  <= divisor;
                        ready <= 1'b0;
`ifdef KOLACHE_DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            r           <= dividend;
                            q_work      <= '1;
                            count       <= '0;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else
`endif
                        begin
                            r      <= '0;
                            q_work <= dividend;
                            count  <= CNT_W'(WIDTH);
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    r      <= rem_next;
                    q_work <= {q_work[WIDTH-2:0], q_bit};
                    count  <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        quotient    <= {q_work[WIDTH-2:0], q_bit};
                        remainder   <= rem_next;
                        div_by_zero <= (dvsr == '0);
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kolache_divider.sv
// Self-checking bench for kolache_divider (WIDTH=16) using a scoreboard of
// expected results and completion latencies.
module tb_kolache_divider;

    localparam int unsigned W = 16;

    typedef struct {
        string       name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   n_cmp;
    int   n_bad;
    int   cyc;
    exp_t sb[$];

    kolache_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.name, "_quot"}, 32'(quotient), 32'(e.q));
                check_eq({e.name, "_rem"},  32'(remainder), 32'(e.r));
                check_eq({e.name, "_dz"},   32'(div_by_zero), 32'(e.dz));
                check_eq({e.name, "_lat"},  32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    // Drive one request and push its expected outcome; returns after acceptance.
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_ready();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 'x;
        divisor  = 'x;
        e.name = name;
        e.acc  = cyc;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
`ifdef KOLACHE_DIV_ZERO_FAST_EN
            e.lat = 1;
`else
            e.lat = W + 1;
`endif
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_quot",  32'(quotient), 32'd0);
        check_eq("rst_rem",   32'(remainder), 32'd0);
        check_eq("rst_dz",    32'(div_by_zero), 32'd0);

        issue("d100_7", 16'd100, 16'd7);
        @(negedge clk);
        check_eq("busy_ready", 32'(ready), 32'd0);
        wait_empty();
        @(negedge clk);
        check_eq("ready_after_done", 32'(ready), 32'd1);

        issue("dffff_1", 16'hFFFF, 16'd1);
        wait_empty();
        repeat (3) @(negedge clk);
        check_eq("hold_idle_quot", 32'(quotient), 32'hFFFF);
        issue("d3_10", 16'd3, 16'd10);
        repeat (4) @(negedge clk);
        check_eq("hold_run_quot", 32'(quotient), 32'hFFFF);
        check_eq("hold_run_rem",  32'(remainder), 32'd0);
        wait_empty();

        issue("d5_0", 16'd5, 16'd0);
        wait_empty();
        issue("d9_3", 16'd9, 16'd3);
        wait_empty();

        // A start during RUN must be ignored: no extra done, no extra result.
        issue("d100_7_busy", 16'd100, 16'd7);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start    = 1'b0;
        check_eq("ignored_start_ready", 32'(ready), 32'd0);
        wait_empty();
        repeat (W + 4) @(negedge clk);

        // Reset in the 8th RUN cycle discards the operation.
        wait_ready();
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(ready), 32'd1);
        check_eq("midrst_done",  32'(done), 32'd0);
        check_eq("midrst_quot",  32'(quotient), 32'd0);
        check_eq("midrst_rem",   32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        issue("d20_6", 16'd20, 16'd6);
        wait_empty();

        // A few extra patterns including boundary operands.
        issue("d0_5", 16'd0, 16'd5);
        issue("dffff_ffff", 16'hFFFF, 16'hFFFF);
        issue("d8000_3", 16'h8000, 16'd3);
        issue("dffff_0", 16'hFFFF, 16'd0);
        issue("d1234_8000", 16'h1234, 16'h8000);
        wait_empty();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
